// File: rtl/bin_to_bcd_seq_if.sv
// Handshake bundle for the sequential binary-to-BCD converter.
// The master drives the start/operand side; the converter is the slave.
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport master (output start, bin, input busy, done, bcd, overflow);
  modport slave  (input start, bin, output busy, done, bcd, overflow);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble converter: one operand bit per clock, MSB first,
// with a sticky overflow flag for operands that do not fit in DIGITS digits.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic            clk,
  input  logic            rst,
  bin_to_bcd_seq_if.slave bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t             state;
  logic [BCD_W-1:0]   scratch;
  logic [WIDTH-1:0]   operand;
  logic [CNT_W-1:0]   count;
  logic               ovf;
  logic               busy_r;
  logic               done_r;
  logic [BCD_W-1:0]   bcd_r;
  logic               overflow_r;
  logic [BCD_W-1:0]   adj;

  // Add 3 to every digit >= 5 so the following left shift carries correctly.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int k = 0; k < DIGITS; k++) begin
      if (s[4*k +: 4] >= 4'd5)
        r[4*k +: 4] = s[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    adj = add3(scratch);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      scratch    <= '0;
      operand    <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      bcd_r      <= '0;
      overflow_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            operand <= bus.bin;
            scratch <= '0;
            ovf     <= 1'b0;
            count   <= CNT_W'(WIDTH);
            busy_r  <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // The bit leaving the top digit means the operand exceeds 10^DIGITS-1.
          scratch <= {adj[BCD_W-2:0], operand[WIDTH-1]};
          ovf     <= ovf | adj[BCD_W-1];
          operand <= {operand[WIDTH-2:0], 1'b0};
          count   <= count - 1'b1;
          if (count == CNT_W'(1))
            state <= FINISH;
        end
        FINISH: begin
          bcd_r      <= scratch;
          overflow_r <= ovf;
          done_r     <= 1'b1;
          busy_r     <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.bcd      = bcd_r;
  assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: three parameterisations side by side, checked
// against a decimal digit-extraction reference model.
module tb_bin_to_bcd_seq;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  bin_to_bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) if_a ();
  bin_to_bcd_seq_if #(.WIDTH(8),  .DIGITS(2)) if_b ();
  bin_to_bcd_seq_if #(.WIDTH(16), .DIGITS(5)) if_c ();

  bin_to_bcd_seq #(.WIDTH(8),  .DIGITS(3)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  bin_to_bcd_seq #(.WIDTH(8),  .DIGITS(2)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal reference: peel off base-10 digits; anything left is overflow.
  function automatic void bcd_ref(input longint v, input int digits,
                                  output logic [39:0] r, output logic ov);
    longint t;
    t = v;
    r = '0;
    for (int k = 0; k < digits; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    ov = (t != 0);
  endfunction

  function automatic logic get_done(input int sel);
    case (sel)
      0:       return if_a.done;
      1:       return if_b.done;
      default: return if_c.done;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0:       return if_a.busy;
      1:       return if_b.busy;
      default: return if_c.busy;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where done is seen, so calls chain back-to-back.
  task automatic run(input int sel, input logic [31:0] v, output int lat,
                     output logic [39:0] b, output logic ov, output logic busy0,
                     output logic busy_end);
    case (sel)
      0:       begin if_a.bin = v[7:0];  if_a.start = 1'b1; end
      1:       begin if_b.bin = v[7:0];  if_b.start = 1'b1; end
      default: begin if_c.bin = v[15:0]; if_c.start = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    case (sel)
      0:       begin if_a.start = 1'b0; if_a.bin = 8'($urandom);  end
      1:       begin if_b.start = 1'b0; if_b.bin = 8'($urandom);  end
      default: begin if_c.start = 1'b0; if_c.bin = 16'($urandom); end
    endcase
    lat = 0;
    busy0 = 1'b0;
    forever begin
      @(negedge clk);
      if (lat == 0) busy0 = get_busy(sel);
      if (get_done(sel)) break;
      lat++;
      if (lat > 40) break;
    end
    case (sel)
      0:       begin b = {28'b0, if_a.bcd}; ov = if_a.overflow; end
      1:       begin b = {32'b0, if_b.bcd}; ov = if_b.overflow; end
      default: begin b = {20'b0, if_c.bcd}; ov = if_c.overflow; end
    endcase
    busy_end = get_busy(sel);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    if_a.start = 1'b1;
    if_a.bin = 8'd77;
    repeat (3) @(negedge clk);
    n_checks++;
    if (if_a.busy !== 1'b0 || if_a.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy_done: busy=%b done=%b required 0 0", if_a.busy, if_a.done);
    end
    n_checks++;
    if (if_a.bcd !== 12'h000 || if_a.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_bcd: bcd=%h ov=%b required 000 0", if_a.bcd, if_a.overflow);
    end
    n_checks++;
    if (if_b.busy !== 1'b0 || if_c.busy !== 1'b0 || if_c.bcd !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_other: busy_b=%b busy_c=%b bcd_c=%h required 0 0 0", if_b.busy, if_c.busy, if_c.bcd);
    end
    if_a.start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_zero();
    int lat; logic [39:0] b; logic ov, b0, be;
    run(0, 32'd0, lat, b, ov, b0, be);
    n_checks++;
    if (lat !== 9 || b[11:0] !== 12'h000 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL zero: lat=%0d bcd=%h ov=%b required 9 000 0", lat, b[11:0], ov);
    end
    n_checks++;
    if (b0 !== 1'b1 || be !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_busy: busy_start=%b busy_at_done=%b required 1 0", b0, be);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [39:0] b; logic ov, b0, be;
    run(0, 32'd255, lat, b, ov, b0, be);
    n_checks++;
    if (lat !== 9 || b[11:0] !== 12'h255 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_255: lat=%0d bcd=%h ov=%b required 9 255 0", lat, b[11:0], ov);
    end
    run(0, 32'd99, lat, b, ov, b0, be);
    n_checks++;
    if (lat !== 9 || b[11:0] !== 12'h099 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_99: lat=%0d bcd=%h ov=%b required 9 099 0", lat, b[11:0], ov);
    end
  endtask

  task automatic test_ignore_start();
    int dones; logic [11:0] seen;
    dones = 0;
    seen = 12'hfff;
    if_a.bin = 8'd200;
    if_a.start = 1'b1;
    @(negedge clk);
    if_a.bin = 8'd7;
    repeat (3) begin
      @(negedge clk);
      if (if_a.done) begin dones++; seen = if_a.bcd; end
    end
    if_a.start = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (if_a.done) begin dones++; seen = if_a.bcd; end
    end
    n_checks++;
    if (dones !== 1 || seen !== 12'h200) begin
      n_fail++;
      $display("FAIL ignore_start: dones=%0d bcd=%h required 1 200", dones, seen);
    end
  endtask

  task automatic test_reset_abort();
    int lat, dones; logic [39:0] b; logic ov, b0, be;
    dones = 0;
    if_a.bin = 8'd128;
    if_a.start = 1'b1;
    @(posedge clk);
    #1;
    if_a.start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (if_a.done) dones++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (if_a.busy !== 1'b0 || if_a.bcd !== 12'h000 || if_a.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: busy=%b bcd=%h ov=%b required 0 000 0", if_a.busy, if_a.bcd, if_a.overflow);
    end
    repeat (15) begin
      @(negedge clk);
      if (if_a.done) dones++;
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL abort_done: dones=%0d required 0", dones);
    end
    run(0, 32'd42, lat, b, ov, b0, be);
    n_checks++;
    if (lat !== 9 || b[11:0] !== 12'h042 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL after_abort: lat=%0d bcd=%h ov=%b required 9 042 0", lat, b[11:0], ov);
    end
  endtask

  task automatic test_two_digits();
    int lat; logic [39:0] b; logic ov, b0, be;
    logic [39:0] eb; logic eov; logic [31:0] v;
    run(1, 32'd255, lat, b, ov, b0, be);
    n_checks++;
    if (lat !== 9 || b[7:0] !== 8'h55 || ov !== 1'b1) begin
      n_fail++;
      $display("FAIL d2_255: lat=%0d bcd=%h ov=%b required 9 55 1", lat, b[7:0], ov);
    end
    repeat (6) @(negedge clk);
    n_checks++;
    if (if_b.bcd !== 8'h55 || if_b.overflow !== 1'b1 || if_b.done !== 1'b0) begin
      n_fail++;
      $display("FAIL d2_hold: bcd=%h ov=%b done=%b required 55 1 0", if_b.bcd, if_b.overflow, if_b.done);
    end
    run(1, 32'd99, lat, b, ov, b0, be);
    n_checks++;
    if (b[7:0] !== 8'h99 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL d2_99: bcd=%h ov=%b required 99 0", b[7:0], ov);
    end
    for (int i = 0; i < 40; i++) begin
      v = 32'($urandom_range(0, 255));
      bcd_ref(longint'(v), 2, eb, eov);
      run(1, v, lat, b, ov, b0, be);
      n_checks++;
      if (lat !== 9 || b[7:0] !== eb[7:0] || ov !== eov) begin
        n_fail++;
        $display("FAIL d2_rand v=%0d: lat=%0d bcd=%h ov=%b required 9 %h %b", v, lat, b[7:0], ov, eb[7:0], eov);
      end
    end
  endtask

  task automatic test_wide();
    int lat; logic [39:0] b; logic ov, b0, be;
    logic [39:0] eb; logic eov; logic [31:0] v;
    run(2, 32'd65535, lat, b, ov, b0, be);
    n_checks++;
    if (lat !== 17 || b[19:0] !== 20'h65535 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL w16_max: lat=%0d bcd=%h ov=%b required 17 65535 0", lat, b[19:0], ov);
    end
    for (int i = 0; i < 30; i++) begin
      v = 32'($urandom_range(0, 65535));
      bcd_ref(longint'(v), 5, eb, eov);
      run(2, v, lat, b, ov, b0, be);
      n_checks++;
      if (lat !== 17 || b[19:0] !== eb[19:0] || ov !== eov) begin
        n_fail++;
        $display("FAIL w16_rand v=%0d: lat=%0d bcd=%h ov=%b required 17 %h %b", v, lat, b[19:0], ov, eb[19:0], eov);
      end
    end
  endtask

  task automatic test_sweep();
    int lat; logic [39:0] b; logic ov, b0, be;
    logic [39:0] eb; logic eov;
    for (int v = 0; v < 256; v++) begin
      bcd_ref(longint'(v), 3, eb, eov);
      run(0, 32'(v), lat, b, ov, b0, be);
      n_checks++;
      if (lat !== 9 || b[11:0] !== eb[11:0] || ov !== eov) begin
        n_fail++;
        $display("FAIL sweep v=%0d: lat=%0d bcd=%h ov=%b required 9 %h %b", v, lat, b[11:0], ov, eb[11:0], eov);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b0;
    if_a.start = 1'b0; if_a.bin = '0;
    if_b.start = 1'b0; if_b.bin = '0;
    if_c.start = 1'b0; if_c.bin = '0;
    test_reset();
    test_zero();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
    test_two_digits();
    test_wide();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the binary input width; legal range 4..32.
REQ-002 The block SHALL have parameter DIGITS, default 3, giving the number of 4-bit BCD output digits; legal range 1..10.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request to convert the value on bin.
REQ-006 The block SHALL have port bin, input, WIDTH bits: unsigned binary operand, sampled only when a start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid new result.
REQ-009 The block SHALL have port bcd, output, 4*DIGITS bits: packed BCD result; digit k occupies bits [4k+3:4k], and k=0 is the units digit.
REQ-010 The block SHALL have port overflow, output, 1 bit: set when the last operand was >= 10^DIGITS.

Function
REQ-011 The block SHALL implement the shift-add-3 (double-dabble) algorithm iteratively, processing one operand bit per clock, MSB first.
REQ-012 The block SHALL use an FSM with states IDLE, SHIFT and FINISH.
REQ-013 In IDLE with start=1, the block SHALL latch bin, clear the digit scratch register, clear the internal overflow flag, load the bit counter with WIDTH, and go to SHIFT.
REQ-014 In SHIFT, each cycle SHALL first add 3 to every scratch digit >= 5, then shift the scratch/operand pair left by one, taking in the operand MSB, and decrement the counter.
REQ-015 Any bit shifted out of the top scratch digit during SHIFT SHALL set the internal overflow flag (sticky for this conversion).
REQ-016 The block SHALL leave SHIFT for FINISH in the cycle the counter reaches 0, after exactly WIDTH shift cycles.
REQ-017 In FINISH, the block SHALL copy scratch to bcd and the internal flag to overflow, assert done for exactly one cycle, and return to IDLE.
REQ-018 busy SHALL be 1 in SHIFT and FINISH and 0 in IDLE.
REQ-019 With start accepted at edge N, done SHALL be high in the cycle following edge N+WIDTH+1, and bcd/overflow SHALL be valid in that same cycle.
REQ-020 start while busy=1 SHALL be ignored; no queuing.
REQ-021 start in the cycle after done, with the FSM in IDLE, SHALL be accepted, giving a back-to-back period of WIDTH+2 cycles.
REQ-022 Changes on bin after acceptance SHALL NOT affect the result in progress.
REQ-023 bcd and overflow SHALL hold the last result until the next FINISH.
REQ-024 On overflow, bcd SHALL equal the operand mod 10^DIGITS.
REQ-025 Every output digit SHALL be in the range 0..9; values 10..15 SHALL never appear.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE and clear busy, done, overflow, bcd, scratch and counter to 0, and any conversion in progress SHALL be aborted with no done.
REQ-027 rst SHALL take priority over start in the same cycle.
REQ-028 After rst is released, the first start SHALL be accepted normally.

Verification (WIDTH=8, DIGITS=3 unless stated)
REQ-029 Bench SHALL cover: reset, then bin=0, start pulse -> done 9 cycles later, bcd=12'h000, overflow=0.
REQ-030 Bench SHALL cover: bin=8'd255, start -> done after 9 cycles, bcd=12'h255, overflow=0; then bin=8'd99 back-to-back -> bcd=12'h099.
REQ-031 Bench SHALL cover: bin=8'd200, start, then start=1 with bin=8'd7 for 3 further cycles -> exactly one done, bcd=12'h200.
REQ-032 Bench SHALL cover: bin=8'd128, start, rst asserted 4 cycles later -> no done, bcd=0, busy=0; then bin=8'd42, start -> bcd=12'h042.
REQ-033 Bench SHALL cover: DIGITS=2, bin=8'd255 -> bcd=8'h55, overflow=1; then bin=8'd99 -> bcd=8'h99, overflow=0.
REQ-034 Bench SHALL cover: WIDTH=16, DIGITS=5, bin=16'd65535 -> done 17 cycles after start, bcd=20'h65535, overflow=0; plus an exhaustive 0..255 sweep at default parameters against a reference model.
